// File: rtl/usb_stream_buffer_pkg.sv
// Package: usb_stream_buffer_pkg
// Purpose : shared defaults and helpers for the USB byte stream buffer.
//   USB_BUF_TX_DEPTH / USB_BUF_RX_DEPTH : default FIFO depths per direction
//   USB_BUF_DATA_W                      : byte width carried by both paths
//   usb_byte_t                          : one data byte
//   lvl_width(depth)                    : bits needed for an occupancy count 0..depth
package usb_stream_buffer_pkg;

  localparam int USB_BUF_TX_DEPTH = 16;
  localparam int USB_BUF_RX_DEPTH = 16;
  localparam int USB_BUF_DATA_W   = 8;

  typedef logic [USB_BUF_DATA_W-1:0] usb_byte_t;

  // Occupancy must represent the full state (level == depth), hence one extra bit.
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/usb_stream_buffer_stream_fifo.sv
// Module : stream_fifo
// Purpose: first-word-fall-through valid/ready FIFO with registered write-side
//          ready, explicit occupancy counter and a synchronous flush.
// Ports:
//   clk_i      in   clock, rising edge
//   rstn_i     in   asynchronous active-low reset
//   flush      in   clears pointers and level on the next edge (wins over push/pop)
//   wr_data    in   WIDTH  write-side byte
//   wr_valid   in   write-side valid
//   wr_ready   out  registered; high when the FIFO can take a byte this cycle
//   rd_data    out  WIDTH  head entry, zero while empty
//   rd_valid   out  high while the FIFO holds at least one entry
//   rd_ready   in   read-side consumer accepts the head entry
//   level      out  occupancy 0..DEPTH
module stream_fifo
  import usb_stream_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = lvl_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0] level_reg, level_next;
  logic             ready_reg;
  logic             push, pop;

  assign push = wr_valid && ready_reg;
  assign pop  = rd_valid && rd_ready;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      level_next = level_reg + LVL_W'(1);
      else if (pop && !push) level_next = level_reg - LVL_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ready_reg  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      // Registered from the next level: a pop while full only frees the slot
      // for the following cycle, so no push can ever target a full array.
      ready_reg  <= (level_next < LVL_W'(DEPTH));
    end
  end

  // Storage has no reset so it maps onto distributed/block RAM; stale contents
  // are never visible because the read data is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push && !flush) mem[wr_ptr_reg] <= wr_data;
  end

  assign wr_ready = ready_reg;
  assign rd_valid = (level_reg != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr_reg] : '0;
  assign level    = level_reg;

endmodule

// File: rtl/usb_stream_buffer.sv
// Module : usb_stream_buffer
// Purpose: bidirectional byte buffer between the CPU USB FIFO interface and the
//          USB_CDC core. TX carries CPU bytes toward the host, RX carries host
//          bytes toward the CPU; the two paths are fully independent.
// Ports:
//   clk_i, rstn_i                      clock (rising edge), async active-low reset
//   cpu_tx_data_i/valid_i/ready_o      CPU -> TX buffer
//   usb_in_data_o/valid_o/ready_i      TX buffer -> USB_CDC (toward host)
//   usb_out_data_i/valid_i/ready_o     USB_CDC (from host) -> RX buffer
//   cpu_rx_data_o/valid_o/ready_i      RX buffer -> CPU
//   tx_flush_i, rx_flush_i             synchronous clear of one path
//   tx_level_o, rx_level_o             occupancy of each path for the I/O map
module usb_stream_buffer
  import usb_stream_buffer_pkg::*;
#(
  parameter int TX_DEPTH = USB_BUF_TX_DEPTH,
  parameter int RX_DEPTH = USB_BUF_RX_DEPTH
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [7:0]                cpu_tx_data_i,
  input  logic                      cpu_tx_valid_i,
  output logic                      cpu_tx_ready_o,
  output logic [7:0]                usb_in_data_o,
  output logic                      usb_in_valid_o,
  input  logic                      usb_in_ready_i,
  input  logic [7:0]                usb_out_data_i,
  input  logic                      usb_out_valid_i,
  output logic                      usb_out_ready_o,
  output logic [7:0]                cpu_rx_data_o,
  output logic                      cpu_rx_valid_o,
  input  logic                      cpu_rx_ready_i,
  input  logic                      tx_flush_i,
  input  logic                      rx_flush_i,
  output logic [$clog2(TX_DEPTH):0] tx_level_o,
  output logic [$clog2(RX_DEPTH):0] rx_level_o
);

  stream_fifo #(.DEPTH(TX_DEPTH), .WIDTH(USB_BUF_DATA_W)) u_tx_fifo (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .flush    (tx_flush_i),
    .wr_data  (cpu_tx_data_i),
    .wr_valid (cpu_tx_valid_i),
    .wr_ready (cpu_tx_ready_o),
    .rd_data  (usb_in_data_o),
    .rd_valid (usb_in_valid_o),
    .rd_ready (usb_in_ready_i),
    .level    (tx_level_o)
  );

  stream_fifo #(.DEPTH(RX_DEPTH), .WIDTH(USB_BUF_DATA_W)) u_rx_fifo (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .flush    (rx_flush_i),
    .wr_data  (usb_out_data_i),
    .wr_valid (usb_out_valid_i),
    .wr_ready (usb_out_ready_o),
    .rd_data  (cpu_rx_data_o),
    .rd_valid (cpu_rx_valid_o),
    .rd_ready (cpu_rx_ready_i),
    .level    (rx_level_o)
  );

endmodule

// File: tb/tb_usb_stream_buffer.sv
// Testbench for usb_stream_buffer: directed stimulus with a scoreboard.
// Stimulus pushes the expected byte into a per-direction queue whenever a push
// handshake is seen; an independent monitor pops and compares on every output
// handshake. Inputs change 1 ns after the rising edge, everything is sampled
// on the falling edge.
module tb_usb_stream_buffer;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [7:0] cpu_tx_data = '0;
  logic       cpu_tx_valid = 1'b0;
  logic       cpu_tx_ready;
  logic [7:0] usb_in_data;
  logic       usb_in_valid;
  logic       usb_in_ready = 1'b0;
  logic [7:0] usb_out_data = '0;
  logic       usb_out_valid = 1'b0;
  logic       usb_out_ready;
  logic [7:0] cpu_rx_data;
  logic       cpu_rx_valid;
  logic       cpu_rx_ready = 1'b0;
  logic       tx_flush = 1'b0;
  logic       rx_flush = 1'b0;
  logic [4:0] tx_level;
  logic [4:0] rx_level;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  usb_stream_buffer #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .cpu_tx_data_i   (cpu_tx_data),
    .cpu_tx_valid_i  (cpu_tx_valid),
    .cpu_tx_ready_o  (cpu_tx_ready),
    .usb_in_data_o   (usb_in_data),
    .usb_in_valid_o  (usb_in_valid),
    .usb_in_ready_i  (usb_in_ready),
    .usb_out_data_i  (usb_out_data),
    .usb_out_valid_i (usb_out_valid),
    .usb_out_ready_o (usb_out_ready),
    .cpu_rx_data_o   (cpu_rx_data),
    .cpu_rx_valid_o  (cpu_rx_valid),
    .cpu_rx_ready_i  (cpu_rx_ready),
    .tx_flush_i      (tx_flush),
    .rx_flush_i      (rx_flush),
    .tx_level_o      (tx_level),
    .rx_level_o      (rx_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tx_push(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    cpu_tx_data  = b;
    cpu_tx_valid = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (cpu_tx_ready) begin
        tx_exp.push_back(b);
        ok = 1'b1;
      end
      step();
    end
    cpu_tx_valid = 1'b0;
    if (!ok) chk("tx_push_timeout", 0, 1);
  endtask

  task automatic rx_push(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    usb_out_data  = b;
    usb_out_valid = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (usb_out_ready) begin
        rx_exp.push_back(b);
        ok = 1'b1;
      end
      step();
    end
    usb_out_valid = 1'b0;
    if (!ok) chk("rx_push_timeout", 0, 1);
  endtask

  // Monitor: one comparison per output handshake on either side.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rstn && usb_in_valid && usb_in_ready && !tx_flush) begin
        checks++;
        if (tx_exp.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got 0x%0h, required no byte", usb_in_data);
        end else begin
          e = tx_exp.pop_front();
          if (usb_in_data !== e) begin
            errors++;
            $display("FAIL tx_data: got 0x%0h, required 0x%0h", usb_in_data, e);
          end else begin
            $display("ok   tx_data: 0x%0h", usb_in_data);
          end
        end
      end
      if (rstn && cpu_rx_valid && cpu_rx_ready && !rx_flush) begin
        checks++;
        if (rx_exp.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: got 0x%0h, required no byte", cpu_rx_data);
        end else begin
          e = rx_exp.pop_front();
          if (cpu_rx_data !== e) begin
            errors++;
            $display("FAIL rx_data: got 0x%0h, required 0x%0h", cpu_rx_data, e);
          end else begin
            $display("ok   rx_data: 0x%0h", cpu_rx_data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    // ---- reset ----
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx_ready", int'(cpu_tx_ready), 0);
    chk("rst_rx_ready", int'(usb_out_ready), 0);
    chk("rst_tx_valid", int'(usb_in_valid), 0);
    chk("rst_rx_valid", int'(cpu_rx_valid), 0);
    chk("rst_tx_level", int'(tx_level), 0);
    chk("rst_rx_level", int'(rx_level), 0);
    chk("rst_tx_data", int'(usb_in_data), 0);
    step();
    rstn = 1'b1;
    step();
    @(negedge clk);
    chk("post_rst_tx_ready", int'(cpu_tx_ready), 1);
    chk("post_rst_rx_ready", int'(usb_out_ready), 1);
    step();

    // ---- TX: three bytes held back, then drained ----
    tx_push(8'h41);
    tx_push(8'h42);
    tx_push(8'h43);
    @(negedge clk);
    chk("tx_level_3", int'(tx_level), 3);
    chk("tx_valid_held", int'(usb_in_valid), 1);
    chk("tx_head_fwft", int'(usb_in_data), 8'h41);
    step();
    usb_in_ready = 1'b1;
    repeat (6) step();
    usb_in_ready = 1'b0;
    @(negedge clk);
    chk("tx_empty_valid", int'(usb_in_valid), 0);
    chk("tx_empty_level", int'(tx_level), 0);
    chk("tx_queue_drained", tx_exp.size(), 0);
    step();

    // ---- RX: fill to 16, pop one while full, 17th byte accepted later ----
    for (int i = 0; i < 16; i++) rx_push(8'(i));
    @(negedge clk);
    chk("rx_level_full", int'(rx_level), 16);
    chk("rx_ready_full", int'(usb_out_ready), 0);
    step();
    usb_out_data  = 8'hFF;
    usb_out_valid = 1'b1;
    cpu_rx_ready  = 1'b1;
    @(negedge clk);
    chk("rx_ready_pop_cycle", int'(usb_out_ready), 0);
    step();
    cpu_rx_ready = 1'b0;
    rx_push(8'hFF);
    @(negedge clk);
    chk("rx_level_refull", int'(rx_level), 16);
    chk("rx_ready_refull", int'(usb_out_ready), 0);
    step();
    cpu_rx_ready = 1'b1;
    repeat (20) step();
    cpu_rx_ready = 1'b0;
    @(negedge clk);
    chk("rx_queue_drained", rx_exp.size(), 0);
    chk("rx_level_drained", int'(rx_level), 0);
    step();

    // ---- TX: steady push+pop at level 5 for 40 cycles ----
    for (int i = 0; i < 5; i++) tx_push(8'h10 + 8'(i));
    for (int i = 0; i < 40; i++) begin
      cpu_tx_data  = 8'h20 + 8'(i);
      cpu_tx_valid = 1'b1;
      usb_in_ready = 1'b1;
      @(negedge clk);
      if (i % 8 == 0) chk("tx_ready_stream", int'(cpu_tx_ready), 1);
      if (cpu_tx_ready) tx_exp.push_back(cpu_tx_data);
      chk("tx_level_stream", int'(tx_level), 5);
      step();
    end
    cpu_tx_valid = 1'b0;
    usb_in_ready = 1'b0;
    @(negedge clk);
    chk("tx_level_after_stream", int'(tx_level), 5);
    step();
    usb_in_ready = 1'b1;
    repeat (10) step();
    usb_in_ready = 1'b0;
    @(negedge clk);
    chk("tx_stream_drained", tx_exp.size(), 0);
    step();

    // ---- RX flush at level 7 with a concurrent push ----
    for (int i = 0; i < 7; i++) rx_push(8'h60 + 8'(i));
    @(negedge clk);
    chk("rx_level_7", int'(rx_level), 7);
    step();
    rx_exp.delete();
    rx_flush      = 1'b1;
    usb_out_data  = 8'h55;
    usb_out_valid = 1'b1;
    step();
    rx_flush      = 1'b0;
    usb_out_valid = 1'b0;
    @(negedge clk);
    chk("rx_flush_level", int'(rx_level), 0);
    chk("rx_flush_valid", int'(cpu_rx_valid), 0);
    chk("rx_flush_ready", int'(usb_out_ready), 1);
    step();
    cpu_rx_ready = 1'b1;  // any surviving byte (e.g. 0x55) hits an empty queue
    repeat (3) step();
    cpu_rx_ready = 1'b0;

    // ---- asynchronous reset mid-burst at TX level 9 ----
    for (int i = 0; i < 9; i++) tx_push(8'h80 + 8'(i));
    @(negedge clk);
    chk("tx_level_9", int'(tx_level), 9);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_valid", int'(usb_in_valid), 0);
    chk("async_rst_ready", int'(cpu_tx_ready), 0);
    chk("async_rst_level", int'(tx_level), 0);
    tx_exp.delete();
    step();
    step();
    rstn = 1'b1;
    step();
    @(negedge clk);
    chk("rel_tx_level", int'(tx_level), 0);
    chk("rel_tx_valid", int'(usb_in_valid), 0);
    chk("rel_tx_ready", int'(cpu_tx_ready), 1);
    step();
    usb_in_ready = 1'b1;  // nothing must come out after the reset
    repeat (3) step();
    usb_in_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
